// File: rtl/grom_initiator.sv
// rtl/grom_initiator.sv - GROM port bus master turning commands into paced single-cycle gs strobes
module grom_initiator #(
  parameter int READY_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grclk_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  cmd_count,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic        err,
  output logic        m,
  output logic        gs,
  output logic        mo,
  output logic [7:0]  d,
  input  logic [7:0]  q,
  input  logic        gready
);

  localparam int            TW      = $clog2(READY_TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_MAX = TW'(READY_TIMEOUT);

  localparam logic [1:0] OP_SETADDR = 2'b00;
  localparam logic [1:0] OP_RDDATA  = 2'b01;
  localparam logic [1:0] OP_WRDATA  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_GAP,
    S_READY_WAIT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    op_q;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic [7:0]    rem_q;
  logic [7:0]    hi_q;
  logic [7:0]    d_q;
  logic          phase_q;
  logic [TW-1:0] tmo_q;
  logic          cmd_ready_q;
  logic          busy_q;
  logic          err_q;
  logic          rsp_valid_q;
  logic          rsp_last_q;
  logic [15:0]   rsp_data_q;

  logic       waiting;
  logic       fire;
  logic [7:0] wbyte;

  // The strobe must line up with the grclk_en cycle itself, so gs is decoded
  // from the registered state and the live enable/ready inputs. The first
  // strobe of a command (STROBE) waits exactly like READY_WAIT.
  assign waiting = (state_q == S_STROBE) || (state_q == S_READY_WAIT);
  assign fire    = waiting && gready && grclk_en;

  // Address bytes go out high byte first; op 10 always sends the latched data byte.
  assign wbyte = (op_q == OP_WRDATA) ? data_q : (phase_q ? addr_q[7:0] : addr_q[15:8]);

  // Outside a strobe the bus rests at read/data-port.
  assign gs = fire;
  assign m  = fire ? op_q[0] : 1'b1;
  assign mo = fire ? (op_q[1] == op_q[0]) : 1'b0;
  assign d  = fire ? wbyte : d_q;

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_data  = rsp_data_q;

  // Command sequencer: accept, strobe, gap, wait for ready, repeat, finish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      addr_q      <= 16'h0000;
      data_q      <= 8'h00;
      rem_q       <= 8'h00;
      hi_q        <= 8'h00;
      d_q         <= 8'h00;
      phase_q     <= 1'b0;
      tmo_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            data_q      <= cmd_data;
            rem_q       <= cmd_count;
            phase_q     <= 1'b0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_STROBE;
          end
        end
        S_STROBE, S_READY_WAIT: begin
          if (fire) begin
            d_q   <= wbyte;
            tmo_q <= '0;
            if (op_q == OP_RDDATA) begin
              rem_q <= rem_q - 8'd1;
            end
            state_q <= S_GAP;
          end else if (!gready) begin
            // Only a stalled responder counts toward the abort; a slow grclk_en never does.
            if (tmo_q == TMO_MAX) begin
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_last_q  <= 1'b1;
              rsp_data_q  <= 16'hFFFF;
              state_q     <= S_DONE;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else begin
            tmo_q <= '0;
          end
        end
        S_GAP: begin
          // q was registered by the responder at the strobe edge, so it is valid here.
          phase_q <= ~phase_q;
          state_q <= S_READY_WAIT;
          case (op_q)
            OP_SETADDR: begin
              if (phase_q) begin
                state_q <= S_DONE;
              end
            end
            OP_RDDATA: begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {8'h00, q};
              rsp_last_q  <= (rem_q == 8'd0);
              if (rem_q == 8'd0) begin
                state_q <= S_DONE;
              end
            end
            OP_WRDATA: begin
              state_q <= S_DONE;
            end
            default: begin
              if (phase_q) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= {hi_q, q};
                rsp_last_q  <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                hi_q <= q;
              end
            end
          endcase
        end
        S_DONE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grom_initiator.sv
// tb/tb_grom_initiator.sv - randomized self-checking bench for grom_initiator with a GROM responder model
module tb_grom_initiator;

  localparam int TMO = 15;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        grclk_en  = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'b00;
  logic [15:0] cmd_addr  = 16'h0000;
  logic [7:0]  cmd_data  = 8'h00;
  logic [7:0]  cmd_count = 8'h00;
  logic [7:0]  q         = 8'h00;
  logic        gready    = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_last, busy, err, m, gs, mo;
  logic [15:0] rsp_data;
  logic [7:0]  d;

  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   ge_mode = 0;
  int   ge_period = 1;
  int   gr_mode = 0;
  int   lowleft = 0;
  bit   gr_kill = 1'b0;
  bit   run_chk = 1'b0;
  bit   prev_gs = 1'b0;
  logic exp_err = 1'b0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  sm  [0:65535];
  logic [15:0] g_addr = 16'h0000;
  logic [15:0] sa = 16'h0000;
  bit          sa_valid = 1'b0;

  logic [16:0] exp_q [$];
  logic [9:0]  exp_s [$];
  logic [9:0]  act_s [$];
  logic [15:0] act_r [$];

  grom_initiator #(.READY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .grclk_en(grclk_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err(err), .m(m), .gs(gs), .mo(mo), .d(d), .q(q), .gready(gready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Pacing: grclk_en pattern and responder readiness, changed just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (ge_mode)
      0:       grclk_en = 1'b1;
      1:       grclk_en = ((cyc % ge_period) == 0);
      default: grclk_en = 1'($urandom_range(0, 1));
    endcase
    if (gr_mode == 2) begin
      gready = !gr_kill;
    end else if (gr_mode == 1) begin
      if (lowleft == 0 && gready && $urandom_range(0, 3) == 0) lowleft = int'($urandom_range(1, 8));
      if (lowleft > 0) begin
        gready = 1'b0;
        lowleft--;
      end else begin
        gready = 1'b1;
      end
    end else begin
      gready = 1'b1;
    end
  end

  // GROM responder: acts on each strobe and logs it.
  initial forever begin
    @(negedge clk);
    if (!reset && gs) begin
      act_s.push_back({m, mo, (m ? 8'h00 : d)});
      case ({m, mo})
        2'b01: g_addr = {g_addr[7:0], d};
        2'b11: begin q = g_addr[15:8]; g_addr = {g_addr[7:0], 8'h00}; end
        2'b10: begin q = mem[g_addr]; g_addr = g_addr + 16'd1; end
        default: begin mem[g_addr] = d; g_addr = g_addr + 16'd1; end
      endcase
    end
    gr_kill = (gr_mode == 2) && (gr_kill || (gs && !reset));
  end

  // Per-cycle compare against bus rules and the expected response queue.
  initial begin : cmp
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (run_chk && !reset) begin
        if (gs) chk("gs_with_en_ready", {30'd0, grclk_en, gready}, 32'd3);
        else    chk("bus_rest_m_mo", {30'd0, m, mo}, 32'd2);
        chk("gs_one_cycle", {31'd0, gs & prev_gs}, 32'd0);
        chk("ready_eq_not_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
        if (cmd_ready) chk("err_flag", {31'd0, err}, {31'd0, exp_err});
        if (rsp_valid) begin
          act_r.push_back(rsp_data);
          chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
            chk("rsp_last", {31'd0, rsp_last}, {31'd0, e[16]});
          end
        end
      end
      prev_gs = gs;
    end
  end

  // Builds the expected strobes and responses from the command semantics, then issues it.
  task automatic start_cmd(input logic [1:0] op, input logic [15:0] a, input logic [7:0] dat,
                           input logic [7:0] cnt, input bit tmo);
    int n;
    exp_s.delete();
    act_s.delete();
    act_r.delete();
    case (op)
      2'b00: begin
        exp_s.push_back({2'b01, a[15:8]});
        exp_s.push_back({2'b01, a[7:0]});
        sa = a;
        sa_valid = 1'b1;
      end
      2'b01: begin
        n = (cnt == 8'd0) ? 256 : int'(cnt);
        if (tmo) n = 1;
        for (int i = 0; i < n; i++) begin
          exp_s.push_back(10'b10_0000_0000);
          exp_q.push_back({(!tmo && i == n - 1), 8'h00, sm[sa]});
          sa = sa + 16'd1;
        end
        if (tmo) exp_q.push_back({1'b1, 16'hFFFF});
      end
      2'b10: begin
        exp_s.push_back({2'b00, dat});
        sm[sa] = dat;
        sa = sa + 16'd1;
      end
      default: begin
        exp_s.push_back(10'b11_0000_0000);
        exp_s.push_back(10'b11_0000_0000);
        exp_q.push_back({1'b1, sa});
        sa_valid = 1'b0;
      end
    endcase
    cmd_op = op; cmd_addr = a; cmd_data = dat; cmd_count = cnt;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    exp_err = tmo;
  endtask

  task automatic finish_cmd();
    bit got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if (cmd_ready) begin got = 1'b1; break; end
    end
    chk("cmd_completes", {31'd0, got}, 32'd1);
    chk("rsp_all_seen", exp_q.size(), 32'd0);
    chk("strobe_count", act_s.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < act_s.size(); i++)
      chk("strobe_fields", 32'(act_s[i]), 32'(exp_s[i]));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t0;
    bit got;
    logic [1:0] op;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      sm[i]  = mem[i];
    end
    mem[16'h6000] = 8'h11; mem[16'h6001] = 8'h22; mem[16'h6002] = 8'h33;
    sm[16'h6000]  = 8'h11; sm[16'h6001]  = 8'h22; sm[16'h6002]  = 8'h33;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_gs", {31'd0, gs}, 32'd0);
    chk("rst_m_mo", {30'd0, m, mo}, 32'd2);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    chk("rst_rsp", {14'd0, rsp_valid, rsp_last, rsp_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    run_chk = 1'b1;

    // Preloaded read-back at 0x6000.
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    chk("addr_strobe_hi", 32'(act_s[0]), 32'h160);
    chk("addr_strobe_lo", 32'(act_s[1]), 32'h100);
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd3, 1'b0); finish_cmd();
    chk("rd3_count", act_r.size(), 32'd3);
    chk("rd3_b0", 32'(act_r[0]), 32'h0011);
    chk("rd3_b1", 32'(act_r[1]), 32'h0022);
    chk("rd3_b2", 32'(act_r[2]), 32'h0033);

    // Write then read back.
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b10, 16'h0000, 8'hA5, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd1, 1'b0); finish_cmd();
    chk("wr_readback", 32'(act_r[0]), 32'h00A5);

    // Sparse grclk_en: 1 in 5, then 1 in 40 (long enable gaps must not time out).
    ge_mode = 1;
    ge_period = 5;
    start_cmd(2'b00, 16'h6001, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd2, 1'b0); finish_cmd();
    chk("slow_en_b0", 32'(act_r[0]), 32'h0022);
    ge_period = 40;
    start_cmd(2'b00, 16'h6001, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd2, 1'b0); finish_cmd();
    chk("slow_en_no_err", {31'd0, err}, 32'd0);
    ge_mode = 0;

    // Responder stalls after the first strobe.
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    gr_mode = 2;
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd3, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (gs) begin got = 1'b1; break; end
    end
    chk("tmo_first_strobe", {31'd0, got}, 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      n++;
      if (err) break;
    end
    chk("tmo_cycles_to_err", n, 32'd18);
    finish_cmd();
    gr_mode = 0;
    chk("tmo_rsp_count", act_r.size(), 32'd2);
    chk("tmo_rsp_ffff", 32'(act_r[1]), 32'hFFFF);
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    start_cmd(2'b00, 16'h8000, 8'h00, 8'h00, 1'b0); finish_cmd();
    chk("err_cleared", {31'd0, err}, 32'd0);

    // Count 0 is a 256-byte burst; nominal pacing must sustain at least a byte per 4 cycles.
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd0, 1'b0);
    t0 = cyc;
    finish_cmd();
    chk("burst256_count", act_r.size(), 32'd256);
    chk("burst256_rate", {31'd0, (cyc - t0) <= 4 * 256 + 2}, 32'd1);

    // Randomized command mix with random enable and ready pacing.
    ge_mode = 2;
    gr_mode = 1;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      if (!sa_valid) op = 2'b00;
      start_cmd(op, 16'($urandom), 8'($urandom), 8'($urandom_range(1, 8)), 1'b0);
      finish_cmd();
    end
    ge_mode = 0;
    gr_mode = 0;

    // Reset in the middle of a 10-byte burst, after the third byte.
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd10, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (act_r.size() >= 3) begin got = 1'b1; break; end
    end
    chk("midrst_third_byte", {31'd0, got}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_gs", {31'd0, gs}, 32'd0);
    chk("midrst_ready_busy", {30'd0, cmd_ready, busy}, 32'd2);
    chk("midrst_rsp", {14'd0, rsp_valid, rsp_last, rsp_data}, 32'd0);
    chk("midrst_bus", {22'd0, m, mo, d}, 32'h200);
    exp_q.delete();
    sa_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    start_cmd(2'b00, 16'h6000, 8'h00, 8'h00, 1'b0); finish_cmd();
    start_cmd(2'b01, 16'h0000, 8'h00, 8'd2, 1'b0); finish_cmd();
    chk("post_rst_read", 32'(act_r[1]), 32'h0022);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
